// File: rtl/eth_frame_builder.sv
// eth_frame_builder: prepends a runtime-programmable HDR_WORDS header to each AXI-Stream payload frame.
// Define FRAME_PAD_EN to zero-pad short frames up to MIN_FRAME_WORDS words.
module eth_frame_builder #(
    parameter int DATA_W = 64,
    parameter int HDR_WORDS = 7,
    parameter int MIN_FRAME_WORDS = 8,
    localparam int KEEP_W = DATA_W / 8
) (
    input  logic              clk156,
    input  logic              rst,
    input  logic              cfg_wr_en,
    input  logic [3:0]        cfg_wr_addr,
    input  logic [DATA_W-1:0] cfg_wr_data,
    input  logic [DATA_W-1:0] s_data,
    input  logic [KEEP_W-1:0] s_keep,
    input  logic              s_valid,
    input  logic              s_last,
    output logic              s_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [KEEP_W-1:0] m_keep,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              tx_busy,
    output logic [31:0]       tx_frame_count,
    output logic [31:0]       tx_byte_count
);
`ifdef FRAME_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, HDR, PAYLOAD, PAD} state_t;
    state_t r_state, w_state;
    logic [3:0] r_idx, w_idx;
    logic [15:0] r_wcnt, w_wcnt, w_wcnt_inc;
    logic [DATA_W-1:0] r_hdr [16];
    logic [DATA_W-1:0] w_data, w_mask;
    logic [KEEP_W-1:0] w_keep;
    logic w_valid, w_last, w_ld, w_acc, w_short;
    logic [31:0] w_pop;

    assign w_ld = !m_valid || m_ready;
    assign s_ready = (r_state == PAYLOAD) && w_ld;
    assign w_acc = s_valid && s_ready;
    assign tx_busy = r_state != IDLE;
    assign w_wcnt_inc = (r_wcnt == 16'hFFFF) ? r_wcnt : r_wcnt + 16'd1;
    // the word being accepted now still leaves the frame below the minimum length
    assign w_short = PAD_EN && (32'(w_wcnt_inc) < MIN_FRAME_WORDS);

    always_comb begin
        w_pop = '0;
        w_mask = '0;
        for (int b = 0; b < KEEP_W; b++) begin
            w_pop = w_pop + 32'(s_keep[b]);
            w_mask[b*8 +: 8] = {8{s_keep[b]}};
        end
    end

    always_comb begin
        w_state = r_state;
        w_idx = r_idx;
        w_wcnt = r_wcnt;
        w_data = m_data;
        w_keep = m_keep;
        w_valid = m_valid;
        w_last = m_last;
        if (w_ld) begin
            w_valid = 1'b0;
            w_last = 1'b0;
        end
        case (r_state)
            IDLE: if (s_valid) begin
                w_state = HDR;
                w_idx = '0;
                w_wcnt = '0;
            end
            HDR: if (w_ld) begin
                w_data = r_hdr[r_idx];
                w_keep = '1;
                w_valid = 1'b1;
                w_idx = r_idx + 4'd1;
                w_wcnt = w_wcnt_inc;
                if (32'(r_idx) == HDR_WORDS - 1) w_state = PAYLOAD;
            end
            PAYLOAD: if (w_acc) begin
                w_valid = 1'b1;
                w_wcnt = w_wcnt_inc;
                w_data = (s_last && w_short) ? (s_data & w_mask) : s_data;
                w_keep = (s_last && w_short) ? '1 : s_keep;
                w_last = s_last && !w_short;
                if (s_last) w_state = w_short ? PAD : IDLE;
            end
            default: if (w_ld) begin
                w_data = '0;
                w_keep = '1;
                w_valid = 1'b1;
                w_wcnt = w_wcnt_inc;
                w_last = 32'(w_wcnt_inc) >= MIN_FRAME_WORDS;
                if (w_last) w_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk156) begin
        if (rst) begin
            r_state <= IDLE;
            r_idx <= '0;
            r_wcnt <= '0;
            m_data <= '0;
            m_keep <= '0;
            m_valid <= 1'b0;
            m_last <= 1'b0;
            tx_frame_count <= '0;
            tx_byte_count <= '0;
            for (int i = 0; i < 16; i++) r_hdr[i] <= '0;
        end else begin
            r_state <= w_state;
            r_idx <= w_idx;
            r_wcnt <= w_wcnt;
            m_data <= w_data;
            m_keep <= w_keep;
            m_valid <= w_valid;
            m_last <= w_last;
            // header is frozen for the whole frame; the cycle leaving IDLE still accepts
            if (cfg_wr_en && !tx_busy && 32'(cfg_wr_addr) < HDR_WORDS) r_hdr[cfg_wr_addr] <= cfg_wr_data;
            if (w_acc) tx_byte_count <= tx_byte_count + w_pop;
            if (m_valid && m_ready && m_last) tx_frame_count <= tx_frame_count + 32'd1;
        end
    end
endmodule
